// File: rtl/conv_mac_engine_pkg.sv
// ============================================================================
// conv_mac_engine_pkg : shared FSM state encoding and saturation-bound helpers
// Revision 1.0
// ============================================================================
`default_nettype none

package conv_mac_engine_pkg;

   typedef enum logic [1:0] {
      ST_ACCUM = 2'd0,
      ST_FINAL = 2'd1,
      ST_OUT   = 2'd2
   } state_e;

   function automatic longint sat_max(input int dw);
      return (longint'(1) <<< (dw - 1)) - longint'(1);
   endfunction

   function automatic longint sat_min(input int dw);
      return -(longint'(1) <<< (dw - 1));
   endfunction

endpackage

`default_nettype wire

// File: rtl/conv_mac_engine_dot_lane.sv
// ============================================================================
// conv_dot_lane : combinational LANES-wide signed multiply and adder-tree sum
// Revision 1.0
// ============================================================================
`default_nettype none

module conv_dot_lane #(
   parameter int DATA_WIDTH = 8,
   parameter int LANES      = 16
) (
   input  logic [LANES*DATA_WIDTH-1:0]                   act,
   input  logic [LANES*DATA_WIDTH-1:0]                   wgt,
   output logic signed [2*DATA_WIDTH+$clog2(LANES)-1:0]  dot
);

   localparam int DOT_W  = 2*DATA_WIDTH + $clog2(LANES);
   localparam int LEVELS = $clog2(LANES);
   localparam int NPOW   = 1 << LEVELS;

   always_comb begin
      logic signed [DOT_W-1:0]        tree [NPOW];
      logic signed [2*DATA_WIDTH-1:0] a_ext;
      logic signed [2*DATA_WIDTH-1:0] w_ext;
      logic signed [2*DATA_WIDTH-1:0] prod;
      a_ext = '0;
      w_ext = '0;
      prod  = '0;
      for (int i = 0; i < NPOW; i++) begin
         tree[i] = '0;
         if (i < LANES) begin
            a_ext   = (2*DATA_WIDTH)'($signed(act[i*DATA_WIDTH +: DATA_WIDTH]));
            w_ext   = (2*DATA_WIDTH)'($signed(wgt[i*DATA_WIDTH +: DATA_WIDTH]));
            prod    = a_ext * w_ext;
            tree[i] = DOT_W'(prod);
         end
      end
      // Pairwise reduction in place; level width halves each pass.
      for (int l = NPOW / 2; l >= 1; l = l / 2) begin
         for (int j = 0; j < l; j++) begin
            tree[j] = tree[2*j] + tree[2*j+1];
         end
      end
      dot = tree[0];
   end

endmodule

`default_nettype wire

// File: rtl/conv_mac_engine.sv
// ============================================================================
// conv_mac_engine : multi-lane MAC window accumulator with bias and requantiser
// Revision 1.0
// ============================================================================
`default_nettype none

module conv_mac_engine
   import conv_mac_engine_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int LANES      = 16,
   parameter int ACC_WIDTH  = 32,
   parameter int TAP_WIDTH  = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [TAP_WIDTH-1:0]          cfg_num_taps,
   input  logic [ACC_WIDTH-1:0]          cfg_bias,
   input  logic [4:0]                    cfg_shift,
   input  logic                          cfg_relu,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [LANES*DATA_WIDTH-1:0]   in_act,
   input  logic [LANES*DATA_WIDTH-1:0]   in_wgt,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic                          out_sat
);

   localparam int DOT_W = 2*DATA_WIDTH + $clog2(LANES);
   localparam int EXT_W = ACC_WIDTH + 2;
   localparam logic signed [EXT_W-1:0] SAT_HI = EXT_W'(sat_max(DATA_WIDTH));
   localparam logic signed [EXT_W-1:0] SAT_LO = EXT_W'(sat_min(DATA_WIDTH));

   state_e                       state_q, state_d;
   logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
   logic [TAP_WIDTH-1:0]         tap_cnt_q, tap_cnt_d;
   logic [TAP_WIDTH-1:0]         taps_q, taps_d;
   logic signed [ACC_WIDTH-1:0]  bias_q, bias_d;
   logic [4:0]                   shift_q, shift_d;
   logic                         relu_q, relu_d;
   logic                         out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0]        out_data_q, out_data_d;
   logic                         out_sat_q, out_sat_d;

   logic signed [DOT_W-1:0]      dot;
   logic                         beat;
   logic                         first_beat;
   logic                         last_beat;
   logic [TAP_WIDTH-1:0]         win_taps;

   logic signed [EXT_W-1:0]      v_ext;
   logic signed [EXT_W-1:0]      half;
   logic signed [EXT_W-1:0]      rq;
   logic [DATA_WIDTH-1:0]        res_data;
   logic                         res_sat;

   conv_dot_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .LANES      (LANES)
   ) u_dot (
      .act (in_act),
      .wgt (in_wgt),
      .dot (dot)
   );

   assign in_ready  = rst_n && (state_q == ST_ACCUM);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;

   // The first beat of a window decides its length from live config, later beats from the captured copy.
   always_comb begin
      beat       = in_valid && in_ready;
      first_beat = (tap_cnt_q == '0);
      if (first_beat) begin
         win_taps = (cfg_num_taps == '0) ? TAP_WIDTH'(1) : cfg_num_taps;
      end else begin
         win_taps = taps_q;
      end
      last_beat = (tap_cnt_q == (win_taps - TAP_WIDTH'(1)));
   end

   always_comb begin
      v_ext = EXT_W'(acc_q) + EXT_W'(bias_q);
      half  = EXT_W'(1) << (shift_q - 5'd1);
      if (shift_q != 5'd0) begin
         rq = (v_ext + half) >>> shift_q;
      end else begin
         rq = v_ext;
      end
      if (relu_q && (rq < 0)) begin
         rq = '0;
      end
      res_sat = 1'b0;
      if (rq > SAT_HI) begin
         rq      = SAT_HI;
         res_sat = 1'b1;
      end else if (rq < SAT_LO) begin
         rq      = SAT_LO;
         res_sat = 1'b1;
      end
      res_data = DATA_WIDTH'(rq);
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      tap_cnt_d   = tap_cnt_q;
      taps_d      = taps_q;
      bias_d      = bias_q;
      shift_d     = shift_q;
      relu_d      = relu_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;
      case (state_q)
         ST_ACCUM: begin
            if (beat) begin
               acc_d = acc_q + ACC_WIDTH'(dot);
               if (first_beat) begin
                  taps_d  = win_taps;
                  bias_d  = cfg_bias;
                  shift_d = cfg_shift;
                  relu_d  = cfg_relu;
               end
               if (last_beat) begin
                  tap_cnt_d = '0;
                  state_d   = ST_FINAL;
               end else begin
                  tap_cnt_d = tap_cnt_q + TAP_WIDTH'(1);
               end
            end
         end
         ST_FINAL: begin
            out_data_d  = res_data;
            out_sat_d   = res_sat;
            out_valid_d = 1'b1;
            acc_d       = '0;
            state_d     = ST_OUT;
         end
         ST_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_ACCUM;
            end
         end
         default: begin
            state_d = ST_ACCUM;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_ACCUM;
         acc_q       <= '0;
         tap_cnt_q   <= '0;
         taps_q      <= '0;
         bias_q      <= '0;
         shift_q     <= '0;
         relu_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         tap_cnt_q   <= tap_cnt_d;
         taps_q      <= taps_d;
         bias_q      <= bias_d;
         shift_q     <= shift_d;
         relu_q      <= relu_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_conv_mac_engine.sv
// ============================================================================
// tb_conv_mac_engine : scoreboard bench with directed cases and random windows
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_conv_mac_engine;

   localparam int DW    = 8;
   localparam int LANES = 16;
   localparam int AW    = 32;
   localparam int TW    = 8;
   localparam int PW    = LANES * DW;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [TW-1:0]  cfg_num_taps = '0;
   logic [AW-1:0]  cfg_bias = '0;
   logic [4:0]     cfg_shift = '0;
   logic           cfg_relu = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [PW-1:0]  in_act = '0;
   logic [PW-1:0]  in_wgt = '0;
   logic           out_valid;
   logic           out_ready;
   logic [DW-1:0]  out_data;
   logic           out_sat;

   logic           bp_random = 1'b0;
   logic           dir_rdy = 1'b1;
   logic           rand_rdy = 1'b1;

   int             n_cmp = 0;
   int             n_bad = 0;
   logic [8:0]     exp_q[$];

   assign out_ready = bp_random ? rand_rdy : dir_rdy;

   always #5 clk = ~clk;

   always @(posedge clk) rand_rdy <= ($urandom_range(0, 3) != 0);

   conv_mac_engine #(
      .DATA_WIDTH (DW),
      .LANES      (LANES),
      .ACC_WIDTH  (AW),
      .TAP_WIDTH  (TW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_num_taps (cfg_num_taps),
      .cfg_bias     (cfg_bias),
      .cfg_shift    (cfg_shift),
      .cfg_relu     (cfg_relu),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_act       (in_act),
      .in_wgt       (in_wgt),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_sat      (out_sat)
   );

   task automatic check(input string name, input longint got, input longint want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
      end
   endtask

   // Monitor: every output handshake is matched against the oldest expectation.
   always @(negedge clk) begin
      logic [8:0] e;
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("out_data", longint'($signed(out_data)), longint'($signed(e[7:0])));
            check("out_sat", longint'(out_sat), longint'(e[8]));
         end
      end
   end

   function automatic logic [PW-1:0] fill(input int v);
      logic [PW-1:0] p;
      for (int i = 0; i < LANES; i++) p[i*DW +: DW] = DW'(v);
      return p;
   endfunction

   // Reference requantisation straight from the arithmetic definition.
   function automatic logic [8:0] model(input longint acc, input longint bias,
                                        input int sh, input bit relu);
      longint v, r;
      bit     sat;
      v   = acc + bias;
      r   = (sh > 0) ? ((v + (longint'(1) <<< (sh - 1))) >>> sh) : v;
      sat = 1'b0;
      if (relu && r < 0) r = 0;
      if (r > 127) begin r = 127; sat = 1'b1; end
      else if (r < -128) begin r = -128; sat = 1'b1; end
      return {sat, 8'(r)};
   endfunction

   task automatic push(input int d, input bit s);
      exp_q.push_back({s, 8'(d)});
   endtask

   task automatic set_cfg(input int taps, input longint bias, input int sh, input bit relu);
      cfg_num_taps = TW'(taps);
      cfg_bias     = AW'(bias);
      cfg_shift    = 5'(sh);
      cfg_relu     = relu;
   endtask

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic send_beat(input logic [PW-1:0] a, input logic [PW-1:0] w);
      int   n;
      logic rdy;
      n = 0;
      in_act   = a;
      in_wgt   = w;
      in_valid = 1'b1;
      do begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!rdy && n < 200);
      if (!rdy) check("in_ready_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic wait_out();
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) check("out_valid_timeout", 0, 1);
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [PW-1:0] a, w;
      longint        acc, bias;
      int            taps, nb, sh, av, wv;
      bit            relu;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", longint'(in_ready), 0);
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_out_data", longint'(out_data), 0);
      check("rst_out_sat", longint'(out_sat), 0);
      sync();
      rst_n = 1'b1;
      sync();

      // Single tap, latency
      set_cfg(1, 0, 0, 0);
      send_beat(fill(1), fill(2));
      push(32, 0);
      @(negedge clk);
      check("lat_final_valid", longint'(out_valid), 0);
      check("lat_final_ready", longint'(in_ready), 0);
      @(negedge clk);
      check("lat_out_valid", longint'(out_valid), 1);
      sync();

      // Three taps with rounding shift
      set_cfg(3, 0, 6, 0);
      repeat (3) send_beat(fill(10), fill(10));
      push(75, 0);
      @(negedge clk);
      check("final_in_ready", longint'(in_ready), 0);
      wait_out();
      sync();

      // Saturation and relu
      set_cfg(1, 0, 0, 0);
      send_beat(fill(127), fill(127));
      push(127, 1);
      send_beat(fill(-128), fill(127));
      push(-128, 1);
      set_cfg(1, 0, 0, 1);
      send_beat(fill(-128), fill(127));
      push(0, 0);

      // Rounding of a negative value and bias only
      set_cfg(1, 0, 1, 0);
      a = '0; w = '0;
      a[7:0] = 8'hFD;
      w[7:0] = 8'h01;
      send_beat(a, w);
      push(-1, 0);
      set_cfg(1, 5, 0, 0);
      send_beat(fill(0), fill(0));
      push(5, 0);
      wait_out();
      sync();

      // Backpressure and mid-window config change
      dir_rdy = 1'b0;
      set_cfg(4, 0, 0, 0);
      send_beat(fill(1), fill(1));
      set_cfg(2, 100, 3, 1);
      send_beat(fill(1), fill(1));
      @(negedge clk);
      check("midwin_in_ready", longint'(in_ready), 1);
      check("midwin_out_valid", longint'(out_valid), 0);
      sync();
      send_beat(fill(1), fill(1));
      send_beat(fill(1), fill(1));
      push(64, 0);
      wait_out();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_out_valid", longint'(out_valid), 1);
         check("bp_out_data", longint'(out_data), 64);
         check("bp_in_ready", longint'(in_ready), 0);
      end
      sync();
      dir_rdy = 1'b1;
      @(negedge clk);
      sync();
      @(negedge clk);
      check("post_hs_in_ready", longint'(in_ready), 1);
      check("post_hs_out_valid", longint'(out_valid), 0);
      sync();

      // Reset mid-window
      set_cfg(4, 0, 0, 0);
      send_beat(fill(3), fill(3));
      send_beat(fill(3), fill(3));
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_in_ready", longint'(in_ready), 0);
      sync();
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_out_valid", longint'(out_valid), 0);
      check("rel_in_ready", longint'(in_ready), 1);
      sync();
      set_cfg(1, 0, 0, 0);
      send_beat(fill(1), fill(1));
      push(16, 0);
      wait_out();
      sync();

      // Random windows against the reference model
      bp_random = 1'b1;
      for (int win = 0; win < 25; win++) begin
         taps = $urandom_range(0, 4);
         nb   = (taps == 0) ? 1 : taps;
         bias = longint'($urandom_range(0, 1 << 21)) - longint'(1 << 20);
         sh   = $urandom_range(0, 12);
         relu = 1'($urandom_range(0, 1));
         set_cfg(taps, bias, sh, relu);
         acc = 0;
         for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < LANES; i++) begin
               a[i*DW +: DW] = DW'($urandom);
               w[i*DW +: DW] = DW'($urandom);
               av = $signed(a[i*DW +: DW]);
               wv = $signed(w[i*DW +: DW]);
               acc += longint'(av * wv);
            end
            repeat ($urandom_range(0, 2)) sync();
            send_beat(a, w);
            if (b == 0 && $urandom_range(0, 1) == 1)
               set_cfg($urandom_range(0, 9), longint'($urandom_range(0, 999)), $urandom_range(0, 31), 1'($urandom));
         end
         exp_q.push_back(model(acc, bias, sh, relu));
      end

      bp_random = 1'b0;
      dir_rdy = 1'b1;
      for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(negedge clk);
      check("queue_drained", longint'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
